process_scheduler: RTL and testbench
====================================

Name: process_scheduler

Overview:
- Sits directly downstream of the quantum counter and consumes its context-switch request, IO-trap request and saved PC.
- Holds a small process table with a saved PC and state per PID, and marks the interrupted process.
- Selects the next READY process round-robin and issues a one-cycle PC load to the fetch stage.
- Falls back to the OS idle address when nothing is runnable; stalls the CPU while a switch is in progress.

Parameters:
- NPROC, 8, number of table entries; PID 0 is the OS and is never scheduled.
- PID_W, 3, PID width; must equal clog2(NPROC).
- OS_IDLE_PC, 32'd0, PC loaded when no user process is READY.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- troca_contexto  in  1  quantum expired (from quantum counter).
- intrucaoIOContexto  in  1  current process executed IO; block it.
- fimProcesso  in  1  current process finished.
- pc_processo_trocado  in  32  PC to resume interrupted process.
- create_valid  in  1  register new process.
- create_pid  in  PID_W  PID to create.
- create_pc  in  32  start PC of new process.
- io_done_valid  in  1  IO completed.
- io_done_pid  in  PID_W  PID whose IO completed.
- pc_load  out  1  one-cycle pulse; fetch takes pc_next.
- pc_next  out  32  PC to load.
- processo_atual  out  PID_W  PID currently running.
- busy  out  1  switch in progress; CPU must stall.
- sched_idle  out  1  high while running OS idle (no READY process).

Behaviour:
- Reset (synchronous): all entries FREE, saved PC 0, FSM IDLE, processo_atual=0, pc_load=0, pc_next=0, busy=0, sched_idle=1. Reset mid-switch aborts the switch with no table writes.
- Entry states: FREE, READY, RUNNING, BLOCKED, DONE.
- FSM states: IDLE -> SAVE -> SCAN -> LOAD -> IDLE. busy=1 in SAVE, SCAN and LOAD.
- IDLE: a switch event is any of fimProcesso, intrucaoIOContexto or troca_contexto.
  - Priority when several are sampled together: fimProcesso > intrucaoIOContexto > troca_contexto.
  - The event and pc_processo_trocado are latched; the FSM goes to SAVE.
  - If processo_atual=0 (OS/idle), troca_contexto and intrucaoIOContexto go straight to SCAN without a SAVE write; fimProcesso is ignored.
- SAVE (1 cycle): write the current entry according to the latched event.
  - fimProcesso: state=DONE, saved PC unchanged.
  - intrucaoIOContexto: state=BLOCKED, PC=latched PC.
  - troca_contexto: state=READY, PC=latched PC.
- SCAN: examines one entry per cycle, starting at (processo_atual+1) mod NPROC and skipping PID 0.
  - It visits at most NPROC-1 entries and ends on the first READY entry.
  - The current process, if just set READY, is the last candidate, so a sole READY process is re-selected.
  - No READY entry found: select PID 0 with pc_next=OS_IDLE_PC.
- LOAD (1 cycle): pc_load=1 and processo_atual=selected PID.
  - pc_next = saved PC of the selected entry, or OS_IDLE_PC if none was found.
  - Selected entry becomes RUNNING; sched_idle = (selected PID == 0).
  - pc_next holds its value after LOAD.
- Worst-case latency from event to pc_load: NPROC+1 cycles (SAVE + NPROC-1 SCAN + LOAD).
- Switch events arriving while busy=1 are ignored (the CPU is stalled, so none are legal).
- create_valid and io_done_valid are accepted in every state, including while busy.
  - create: entry := READY, PC=create_pc. Ignored if create_pid=0 or the entry is not FREE/DONE.
  - io_done: entry BLOCKED -> READY, PC kept. Ignored for any other state.
  - Write ordering in one cycle: SAVE write first, then io_done, then create (last writer wins). Blocked-then-io_done in the same SAVE cycle therefore ends READY.
  - An entry that becomes READY during SCAN is found only if SCAN has not yet passed it.
- In sched_idle, io_done or create does not preempt the OS; the next troca_contexto from the quantum counter triggers SCAN.
- Widths: PID increment wraps modulo NPROC. PCs are stored unmodified (the +1 is applied upstream).

Decomposition:
- Shared package (sched_pkg):
  - entry-state enum (FREE/READY/RUNNING/BLOCKED/DONE).
  - FSM state enum.
  - constants NPROC, PID_W, OS_IDLE_PC, and PID_OS=0.
- One sub-module: proc_table, the NPROC-entry state+PC register file.
  - One prioritised write-port group (save/io_done/create).
  - Combinational read by index for SCAN.

Test Plan:
- Reset, create PID1 PC=400 and PID2 PC=500, then troca_contexto with pc_processo_trocado=0 while in OS -> pc_load with pc_next=400, processo_atual=1; next troca_contexto with pc=406 -> pc_next=500, PID1 READY with PC 406.
- PID1 running, PID2 READY, intrucaoIOContexto with pc=410 -> PID1 BLOCKED at 410, pc_next=PID2's PC; io_done_pid=1 -> PID1 READY; next troca_contexto -> pc_next=410.
- Only PID3 exists and troca_contexto with pc=701 -> PID3 re-selected, pc_next=701; pc_load arrives exactly NPROC+1=9 cycles after the event.
- All processes BLOCKED, last one issues IO -> pc_next=OS_IDLE_PC=0, processo_atual=0, sched_idle=1.
- fimProcesso and troca_contexto in the same cycle for PID2 -> PID2 DONE (not READY); create_pid=2 PC=900 afterwards is accepted.
- Reset asserted in the SCAN cycle -> no pc_load; all outputs at reset values the next cycle; table all FREE.

Source files
------------

// File: rtl/sched_pkg.sv
// sched_pkg: shared types and constants for the process scheduler.
//   NPROC       number of process-table entries (PID 0 is the OS)
//   PID_W       PID width, clog2(NPROC)
//   OS_IDLE_PC  PC loaded when no user process is READY
//   PID_OS      PID reserved for the OS, never scheduled
package sched_pkg;

  localparam int               NPROC      = 8;
  localparam int               PID_W      = $clog2(NPROC);
  localparam logic [31:0]      OS_IDLE_PC = 32'd0;
  localparam logic [PID_W-1:0] PID_OS     = '0;

  typedef enum logic [2:0] {
    ST_FREE,
    ST_READY,
    ST_RUNNING,
    ST_BLOCKED,
    ST_DONE
  } entry_st_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_SCAN,
    S_LOAD
  } fsm_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_FIM,
    EV_IO,
    EV_TROCA
  } event_t;

  // Round-robin successor; the OS slot is stepped over without costing a cycle.
  function automatic logic [PID_W-1:0] next_pid(input logic [PID_W-1:0] p);
    logic [PID_W-1:0] n;
    n = p + PID_W'(1);
    if (n == PID_OS) n = PID_OS + PID_W'(1);
    return n;
  endfunction

endpackage

// File: rtl/proc_table.sv
// proc_table: NPROC-entry register file holding state and saved PC per PID.
//   run_*   mark the newly loaded process RUNNING
//   save_*  write-back of the interrupted process (state, optional PC)
//   io_*    IO completion: BLOCKED -> READY
//   cr_*    process creation: FREE/DONE -> READY with a start PC
//   rd_*    combinational read by PID for the scan
module proc_table
  import sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             run_en,
  input  logic [PID_W-1:0] run_pid,
  input  logic             save_en,
  input  logic [PID_W-1:0] save_pid,
  input  entry_st_t        save_st,
  input  logic             save_pc_en,
  input  logic [31:0]      save_pc,
  input  logic             io_en,
  input  logic [PID_W-1:0] io_pid,
  input  logic             cr_en,
  input  logic [PID_W-1:0] cr_pid,
  input  logic [31:0]      cr_pc,
  input  logic [PID_W-1:0] rd_pid,
  output entry_st_t        rd_st,
  output logic [31:0]      rd_pc
);

  entry_st_t   st_q [NPROC];
  entry_st_t   st_d [NPROC];
  logic [31:0] pc_q [NPROC];
  logic [31:0] pc_d [NPROC];

  // Writers are applied in order so the later one sees the earlier one's
  // result: a process blocked in SAVE and released by io_done in the same
  // cycle ends up READY.
  always_comb begin
    for (int i = 0; i < NPROC; i++) begin
      st_d[i] = st_q[i];
      pc_d[i] = pc_q[i];
      if (run_en && run_pid == PID_W'(i)) st_d[i] = ST_RUNNING;
      if (save_en && save_pid == PID_W'(i)) begin
        st_d[i] = save_st;
        if (save_pc_en) pc_d[i] = save_pc;
      end
      if (io_en && io_pid == PID_W'(i) && st_d[i] == ST_BLOCKED) st_d[i] = ST_READY;
      if (cr_en && cr_pid == PID_W'(i) && cr_pid != PID_OS &&
          (st_d[i] == ST_FREE || st_d[i] == ST_DONE)) begin
        st_d[i] = ST_READY;
        pc_d[i] = cr_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) begin
        st_q[i] <= ST_FREE;
        pc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        st_q[i] <= st_d[i];
        pc_q[i] <= pc_d[i];
      end
    end
  end

  assign rd_st = st_q[rd_pid];
  assign rd_pc = pc_q[rd_pid];

endmodule

// File: rtl/process_scheduler.sv
// process_scheduler: round-robin context switcher fed by the quantum counter.
//   troca_contexto / intrucaoIOContexto / fimProcesso  switch events
//   pc_processo_trocado  resume PC of the interrupted process
//   create_*, io_done_*  table updates, accepted in every state
//   pc_load/pc_next      one-cycle PC load towards fetch
//   processo_atual       running PID; busy stalls the CPU; sched_idle = OS idle
//
// state  | meaning
// S_IDLE | a process (or the OS idle loop) runs; waiting for a switch event
// S_SAVE | write back the interrupted process per the latched event
// S_SCAN | test one candidate PID per cycle for READY
// S_LOAD | pc_load pulse, selected PID marked RUNNING
module process_scheduler
  import sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             troca_contexto,
  input  logic             intrucaoIOContexto,
  input  logic             fimProcesso,
  input  logic [31:0]      pc_processo_trocado,
  input  logic             create_valid,
  input  logic [PID_W-1:0] create_pid,
  input  logic [31:0]      create_pc,
  input  logic             io_done_valid,
  input  logic [PID_W-1:0] io_done_pid,
  output logic             pc_load,
  output logic [31:0]      pc_next,
  output logic [PID_W-1:0] processo_atual,
  output logic             busy,
  output logic             sched_idle
);

  fsm_t             state_q, state_d;
  event_t           ev_q, ev_d;
  logic [31:0]      saved_pc_q, saved_pc_d;
  logic [PID_W-1:0] scan_idx_q, scan_idx_d;
  logic [PID_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [PID_W-1:0] cur_q, cur_d;
  logic             pc_load_q, pc_load_d;
  logic [31:0]      pc_next_q, pc_next_d;
  logic             busy_q, busy_d;
  logic             idle_q, idle_d;

  logic             save_en, save_pc_en, run_en;
  entry_st_t        save_st;
  entry_st_t        rd_st;
  logic [31:0]      rd_pc;

  always_comb begin
    state_d    = state_q;
    ev_d       = ev_q;
    saved_pc_d = saved_pc_q;
    scan_idx_d = scan_idx_q;
    scan_cnt_d = scan_cnt_q;
    cur_d      = cur_q;
    pc_load_d  = 1'b0;
    pc_next_d  = pc_next_q;
    busy_d     = busy_q;
    idle_d     = idle_q;
    save_en    = 1'b0;
    save_pc_en = 1'b0;
    save_st    = ST_READY;
    run_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cur_q == PID_OS) begin
          // Nothing to save for the OS; a finish from it is meaningless.
          if (troca_contexto || intrucaoIOContexto) begin
            state_d    = S_SCAN;
            busy_d     = 1'b1;
            scan_idx_d = next_pid(PID_OS);
            scan_cnt_d = PID_W'(NPROC - 2);
          end
        end else if (fimProcesso || intrucaoIOContexto || troca_contexto) begin
          ev_d       = fimProcesso ? EV_FIM : (intrucaoIOContexto ? EV_IO : EV_TROCA);
          saved_pc_d = pc_processo_trocado;
          state_d    = S_SAVE;
          busy_d     = 1'b1;
        end
      end
      S_SAVE: begin
        save_en = 1'b1;
        case (ev_q)
          EV_FIM:  save_st = ST_DONE;
          EV_IO:   begin save_st = ST_BLOCKED; save_pc_en = 1'b1; end
          default: begin save_st = ST_READY;   save_pc_en = 1'b1; end
        endcase
        state_d    = S_SCAN;
        scan_idx_d = next_pid(cur_q);
        scan_cnt_d = PID_W'(NPROC - 2);
      end
      S_SCAN: begin
        // scan_cnt is a down-counter of remaining candidates; at zero the
        // current entry is the last one (the interrupted process itself).
        if (rd_st == ST_READY) begin
          state_d   = S_LOAD;
          cur_d     = scan_idx_q;
          pc_next_d = rd_pc;
          idle_d    = 1'b0;
          pc_load_d = 1'b1;
        end else if (scan_cnt_q == '0) begin
          state_d   = S_LOAD;
          cur_d     = PID_OS;
          pc_next_d = OS_IDLE_PC;
          idle_d    = 1'b1;
          pc_load_d = 1'b1;
        end else begin
          scan_cnt_d = scan_cnt_q - PID_W'(1);
          scan_idx_d = next_pid(scan_idx_q);
        end
      end
      S_LOAD: begin
        run_en  = (cur_q != PID_OS);
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ev_q       <= EV_NONE;
      saved_pc_q <= '0;
      scan_idx_q <= '0;
      scan_cnt_q <= '0;
      cur_q      <= PID_OS;
      pc_load_q  <= 1'b0;
      pc_next_q  <= '0;
      busy_q     <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ev_q       <= ev_d;
      saved_pc_q <= saved_pc_d;
      scan_idx_q <= scan_idx_d;
      scan_cnt_q <= scan_cnt_d;
      cur_q      <= cur_d;
      pc_load_q  <= pc_load_d;
      pc_next_q  <= pc_next_d;
      busy_q     <= busy_d;
      idle_q     <= idle_d;
    end
  end

  proc_table u_table (
    .clock      (clock),
    .reset      (reset),
    .run_en     (run_en),
    .run_pid    (cur_q),
    .save_en    (save_en),
    .save_pid   (cur_q),
    .save_st    (save_st),
    .save_pc_en (save_pc_en),
    .save_pc    (saved_pc_q),
    .io_en      (io_done_valid),
    .io_pid     (io_done_pid),
    .cr_en      (create_valid),
    .cr_pid     (create_pid),
    .cr_pc      (create_pc),
    .rd_pid     (scan_idx_q),
    .rd_st      (rd_st),
    .rd_pc      (rd_pc)
  );

  assign pc_load        = pc_load_q;
  assign pc_next        = pc_next_q;
  assign processo_atual = cur_q;
  assign busy           = busy_q;
  assign sched_idle     = idle_q;

endmodule

// File: tb/tb_process_scheduler.sv
module tb_process_scheduler;
  import sched_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             troca_contexto, intrucaoIOContexto, fimProcesso;
  logic [31:0]      pc_processo_trocado;
  logic             create_valid;
  logic [PID_W-1:0] create_pid;
  logic [31:0]      create_pc;
  logic             io_done_valid;
  logic [PID_W-1:0] io_done_pid;
  logic             pc_load;
  logic [31:0]      pc_next;
  logic [PID_W-1:0] processo_atual;
  logic             busy, sched_idle;

  int tests = 0;
  int fails = 0;

  process_scheduler dut (
    .clock               (clock),
    .reset               (reset),
    .troca_contexto      (troca_contexto),
    .intrucaoIOContexto  (intrucaoIOContexto),
    .fimProcesso         (fimProcesso),
    .pc_processo_trocado (pc_processo_trocado),
    .create_valid        (create_valid),
    .create_pid          (create_pid),
    .create_pc           (create_pc),
    .io_done_valid       (io_done_valid),
    .io_done_pid         (io_done_pid),
    .pc_load             (pc_load),
    .pc_next             (pc_next),
    .processo_atual      (processo_atual),
    .busy                (busy),
    .sched_idle          (sched_idle)
  );

  always #5 clock = ~clock;

  // Reference model: process table as plain arrays, scheduling by the rules.
  entry_st_t   m_st [NPROC];
  logic [31:0] m_pc [NPROC];
  int          m_cur;
  logic [31:0] m_pcn;
  bit          m_idle;

  typedef struct {
    int          c_pid;
    logic [31:0] c_pc;
    int          io_pid;
    bit          f, io, tr;
    logic [31:0] ev_pc;
    bit          exp_load;
    int          exp_lat;
    logic [31:0] exp_pc;
    int          exp_pid;
    bit          exp_idle;
    int          chk_pid;
    entry_st_t   chk_st;
    logic [31:0] chk_pc;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    troca_contexto = 1'b0; intrucaoIOContexto = 1'b0; fimProcesso = 1'b0;
    pc_processo_trocado = '0;
    create_valid = 1'b0; create_pid = '0; create_pc = '0;
    io_done_valid = 1'b0; io_done_pid = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPROC; i++) begin
      m_st[i] = ST_FREE;
      m_pc[i] = '0;
    end
    m_cur = 0; m_pcn = OS_IDLE_PC; m_idle = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_create(input int pid, input logic [31:0] pc);
    create_valid = 1'b1; create_pid = PID_W'(pid); create_pc = pc;
    tick();
    create_valid = 1'b0;
    if (pid != 0 && (m_st[pid] == ST_FREE || m_st[pid] == ST_DONE)) begin
      m_st[pid] = ST_READY;
      m_pc[pid] = pc;
    end
  endtask

  task automatic do_iodone(input int pid);
    io_done_valid = 1'b1; io_done_pid = PID_W'(pid);
    tick();
    io_done_valid = 1'b0;
    if (m_st[pid] == ST_BLOCKED) m_st[pid] = ST_READY;
  endtask

  // Drives one switch event and measures the response. lat counts clock
  // edges from the sampling edge (inclusive) to the edge raising pc_load.
  task automatic apply_event(input bit f, input bit io, input bit tr, input logic [31:0] pc,
                             output bit got, output bit bsy1, output int lat,
                             output logic [31:0] pcn, output int pid, output bit idl);
    int n;
    got = 1'b0; lat = 0; pcn = '0; pid = 0; idl = 1'b0;
    fimProcesso = f; intrucaoIOContexto = io; troca_contexto = tr; pc_processo_trocado = pc;
    tick();
    fimProcesso = 1'b0; intrucaoIOContexto = 1'b0; troca_contexto = 1'b0;
    bsy1 = busy;
    n = 1;
    while (!pc_load && n < 20) begin
      tick();
      n++;
    end
    if (pc_load) begin
      got = 1'b1; lat = n; pcn = pc_next; pid = int'(processo_atual); idl = sched_idle;
      tick();
      check("load pulse width", 32'(pc_load), 32'd0);
      check("busy after load", 32'(busy), 32'd0);
    end
  endtask

  task automatic model_event(input bit f, input bit io, input bit tr, input logic [31:0] pc,
                             output bit sw, output int lat);
    int visited, sel, p;
    bit save;
    lat = 0;
    sw = !(m_cur == 0 && !io && !tr);
    if (!sw) return;
    save = (m_cur != 0);
    if (save) begin
      if (f) m_st[m_cur] = ST_DONE;
      else if (io) begin m_st[m_cur] = ST_BLOCKED; m_pc[m_cur] = pc; end
      else begin m_st[m_cur] = ST_READY; m_pc[m_cur] = pc; end
    end
    sel = 0; visited = 0;
    for (int k = 1; k <= NPROC; k++) begin
      p = (m_cur + k) % NPROC;
      if (p == 0) continue;
      visited++;
      if (m_st[p] == ST_READY) begin sel = p; break; end
    end
    if (sel != 0) begin
      m_st[sel] = ST_RUNNING; m_cur = sel; m_pcn = m_pc[sel]; m_idle = 1'b0;
    end else begin
      m_cur = 0; m_pcn = OS_IDLE_PC; m_idle = 1'b1;
    end
    lat = int'(save) + visited + 1;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < NPROC; i++) begin
      check($sformatf("%s st[%0d]", tag, i), 32'(dut.u_table.st_q[i]), 32'(m_st[i]));
      check($sformatf("%s pc[%0d]", tag, i), dut.u_table.pc_q[i], m_pc[i]);
    end
  endtask

  task automatic run_table();
    bit got, bsy1, idl;
    int lat, pid;
    logic [31:0] pcn;
    vt[0]  = '{1,  400, -1, 1'b0, 1'b0, 1'b0, 0,   1'b0, 0, 0,   0, 1'b1, 1, ST_READY,   400};
    vt[1]  = '{2,  500, -1, 1'b0, 1'b0, 1'b1, 0,   1'b1, 2, 400, 1, 1'b0, 1, ST_RUNNING, 400};
    vt[2]  = '{-1, 0,   -1, 1'b0, 1'b0, 1'b1, 406, 1'b1, 3, 500, 2, 1'b0, 1, ST_READY,   406};
    vt[3]  = '{-1, 0,   -1, 1'b0, 1'b0, 1'b1, 506, 1'b1, 8, 406, 1, 1'b0, 2, ST_READY,   506};
    vt[4]  = '{-1, 0,   -1, 1'b0, 1'b1, 1'b0, 410, 1'b1, 3, 506, 2, 1'b0, 1, ST_BLOCKED, 410};
    vt[5]  = '{-1, 0,   1,  1'b0, 1'b0, 1'b0, 0,   1'b0, 0, 506, 2, 1'b0, 1, ST_READY,   410};
    vt[6]  = '{-1, 0,   -1, 1'b0, 1'b0, 1'b1, 512, 1'b1, 8, 410, 1, 1'b0, 2, ST_READY,   512};
    vt[7]  = '{-1, 0,   -1, 1'b0, 1'b1, 1'b0, 420, 1'b1, 3, 512, 2, 1'b0, 1, ST_BLOCKED, 420};
    vt[8]  = '{-1, 0,   -1, 1'b0, 1'b1, 1'b0, 520, 1'b1, 9, 0,   0, 1'b1, 2, ST_BLOCKED, 520};
    vt[9]  = '{-1, 0,   2,  1'b0, 1'b0, 1'b0, 0,   1'b0, 0, 0,   0, 1'b1, 2, ST_READY,   520};
    vt[10] = '{-1, 0,   -1, 1'b0, 1'b0, 1'b1, 0,   1'b1, 3, 520, 2, 1'b0, 2, ST_RUNNING, 520};
    vt[11] = '{-1, 0,   -1, 1'b1, 1'b0, 1'b1, 530, 1'b1, 9, 0,   0, 1'b1, 2, ST_DONE,    520};
    vt[12] = '{2,  900, -1, 1'b0, 1'b0, 1'b0, 0,   1'b0, 0, 0,   0, 1'b1, 2, ST_READY,   900};
    vt[13] = '{2,  950, -1, 1'b0, 1'b0, 1'b0, 0,   1'b0, 0, 0,   0, 1'b1, 2, ST_READY,   900};
    vt[14] = '{0,  77,  -1, 1'b1, 1'b0, 1'b0, 0,   1'b0, 0, 0,   0, 1'b1, 0, ST_FREE,    0};
    vt[15] = '{-1, 0,   1,  1'b0, 1'b0, 1'b1, 0,   1'b1, 2, 420, 1, 1'b0, 1, ST_RUNNING, 420};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (vt[i].c_pid >= 0) do_create(vt[i].c_pid, vt[i].c_pc);
      if (vt[i].io_pid >= 0) do_iodone(vt[i].io_pid);
      if (vt[i].f || vt[i].io || vt[i].tr) begin
        apply_event(vt[i].f, vt[i].io, vt[i].tr, vt[i].ev_pc, got, bsy1, lat, pcn, pid, idl);
        check($sformatf("vec%0d pc_load", i), 32'(got), 32'(vt[i].exp_load));
        check($sformatf("vec%0d busy", i), 32'(bsy1), 32'(vt[i].exp_load));
        if (vt[i].exp_load) begin
          check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
          check($sformatf("vec%0d pc_next", i), pcn, vt[i].exp_pc);
          check($sformatf("vec%0d pid", i), 32'(pid), 32'(vt[i].exp_pid));
          check($sformatf("vec%0d sched_idle", i), 32'(idl), 32'(vt[i].exp_idle));
        end
      end
      if (!vt[i].exp_load) begin
        check($sformatf("vec%0d pc_next hold", i), pc_next, vt[i].exp_pc);
        check($sformatf("vec%0d pid hold", i), 32'(processo_atual), 32'(vt[i].exp_pid));
        check($sformatf("vec%0d idle hold", i), 32'(sched_idle), 32'(vt[i].exp_idle));
      end
      check($sformatf("vec%0d entry st", i), 32'(dut.u_table.st_q[vt[i].chk_pid]), 32'(vt[i].chk_st));
      check($sformatf("vec%0d entry pc", i), dut.u_table.pc_q[vt[i].chk_pid], vt[i].chk_pc);
    end
  endtask

  task automatic run_hand();
    bit got, bsy1, idl, seen;
    int lat, pid, n;
    logic [31:0] pcn;
    // Sole process is re-selected after a full scan.
    do_reset();
    do_create(3, 700);
    apply_event(1'b0, 1'b0, 1'b1, 0, got, bsy1, lat, pcn, pid, idl);
    check("sole first lat", 32'(lat), 32'd4);
    check("sole first pc", pcn, 32'd700);
    apply_event(1'b0, 1'b0, 1'b1, 701, got, bsy1, lat, pcn, pid, idl);
    check("sole reselect lat", 32'(lat), 32'(NPROC + 1));
    check("sole reselect pc", pcn, 32'd701);
    check("sole reselect pid", 32'(pid), 32'd3);
    check("sole entry st", 32'(dut.u_table.st_q[3]), 32'(ST_RUNNING));

    // IO block released in the SAVE cycle, plus a create while busy.
    do_reset();
    do_create(4, 440);
    apply_event(1'b0, 1'b0, 1'b1, 0, got, bsy1, lat, pcn, pid, idl);
    check("p4 start lat", 32'(lat), 32'd5);
    intrucaoIOContexto = 1'b1; pc_processo_trocado = 444;
    tick();
    intrucaoIOContexto = 1'b0;
    io_done_valid = 1'b1; io_done_pid = 3'd4;
    create_valid = 1'b1; create_pid = 3'd5; create_pc = 555;
    tick();
    io_done_valid = 1'b0; create_valid = 1'b0;
    n = 2;
    while (!pc_load && n < 20) begin tick(); n++; end
    check("save+io_done lat", 32'(n), 32'd3);
    check("save+io_done pc", pc_next, 32'd555);
    check("save+io_done pid", 32'(processo_atual), 32'd5);
    check("save+io_done p4 st", 32'(dut.u_table.st_q[4]), 32'(ST_READY));
    check("save+io_done p4 pc", dut.u_table.pc_q[4], 32'd444);
    tick();

    // Reset during SCAN aborts the switch.
    troca_contexto = 1'b1; pc_processo_trocado = 560;
    tick();
    troca_contexto = 1'b0;
    tick();
    check("in scan busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst scan pc_load", 32'(pc_load), 32'd0);
    check("rst scan pc_next", pc_next, 32'd0);
    check("rst scan pid", 32'(processo_atual), 32'd0);
    check("rst scan busy", 32'(busy), 32'd0);
    check("rst scan idle", 32'(sched_idle), 32'd1);
    model_reset();
    check_table("rst scan");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pc_load) seen = 1'b1;
    end
    check("no load after reset", 32'(seen), 32'd0);
  endtask

  task automatic run_random();
    bit got, bsy1, idl, sw, f, io, tr;
    int lat, pid, a, mlat, bits;
    logic [31:0] pcn, pc;
    do_reset();
    for (int it = 0; it < 200; it++) begin
      a = $urandom_range(0, 9);
      if (a <= 2) do_create($urandom_range(0, NPROC - 1), $urandom);
      else if (a <= 4) do_iodone($urandom_range(0, NPROC - 1));
      else begin
        if (m_cur == 0) bits = $urandom_range(0, 1) ? 1 : 2;
        else bits = $urandom_range(1, 7);
        tr = bits[0]; io = bits[1]; f = bits[2];
        pc = $urandom;
        model_event(f, io, tr, pc, sw, mlat);
        apply_event(f, io, tr, pc, got, bsy1, lat, pcn, pid, idl);
        check($sformatf("rnd%0d pc_load", it), 32'(got), 32'(sw));
        if (sw) begin
          check($sformatf("rnd%0d latency", it), 32'(lat), 32'(mlat));
          check($sformatf("rnd%0d pc_next", it), pcn, m_pcn);
          check($sformatf("rnd%0d pid", it), 32'(pid), 32'(m_cur));
          check($sformatf("rnd%0d idle", it), 32'(idl), 32'(m_idle));
        end
        check_table($sformatf("rnd%0d", it));
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    check("reset pc_load", 32'(pc_load), 32'd0);
    check("reset pc_next", pc_next, 32'd0);
    check("reset pid", 32'(processo_atual), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset idle", 32'(sched_idle), 32'd1);
    reset = 1'b0;
    model_reset();
    check_table("reset");
    run_table();
    run_hand();
    run_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
